// File: rtl/vga_pkg.sv
// Shared constants and FSM state type for the rectangle fill engine.
// Sized for the 160x120, 3-bit colour VGA adapter.
package vga_pkg;

    localparam int XRES    = 160;
    localparam int YRES    = 120;
    localparam int XW      = 8;
    localparam int YW      = 7;
    localparam int COLOR_W = 3;

    // Screen limits widened by one bit so clip sums never wrap.
    localparam logic [XW:0] XLIM = (XW+1)'(XRES);
    localparam logic [YW:0] YLIM = (YW+1)'(YRES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rect_fill_engine.sv
// Command-driven rectangle plotter: one clipped pixel write per cycle.
// Build option: RECT_OUTLINE_EN adds cmd_outline (perimeter-only plotting).
//
// Ports:
//   CLOCK_50, reset          clock, async active-high reset
//   cmd_valid / cmd_ready    command handshake (ready while IDLE)
//   cmd_x/y/w/h/colour       rectangle; cmd_outline with RECT_OUTLINE_EN
//   vga_stall                hold the scan, emit no pixel
//   vga_x/y/colour/plot      registered pixel write to the VGA adapter
//   busy, done               command in flight, completion pulse
module rect_fill_engine
    import vga_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [XW-1:0]      cmd_x,
    input  logic [YW-1:0]      cmd_y,
    input  logic [XW-1:0]      cmd_w,
    input  logic [YW-1:0]      cmd_h,
    input  logic [COLOR_W-1:0] cmd_colour,
`ifdef RECT_OUTLINE_EN
    input  logic               cmd_outline,
`endif
    input  logic               vga_stall,
    output logic [XW-1:0]      vga_x,
    output logic [YW-1:0]      vga_y,
    output logic [COLOR_W-1:0] vga_colour,
    output logic               vga_plot,
    output logic               busy,
    output logic               done
);

    localparam logic [XW:0] X1 = (XW+1)'(1);
    localparam logic [YW:0] Y1 = (YW+1)'(1);

    state_t               state_q, state_d;
    logic [XW-1:0]        x0_q, x0_d, cx_q, cx_d;
    logic [YW-1:0]        y0_q, y0_d, cy_q, cy_d;
    logic [XW:0]          xend_q, xend_d;
    logic [YW:0]          yend_q, yend_d;
    logic [COLOR_W-1:0]   col_q, col_d;
    logic                 last_q, last_d;
    logic [XW-1:0]        vx_q, vx_d;
    logic [YW-1:0]        vy_q, vy_d;
    logic [COLOR_W-1:0]   vc_q, vc_d;
    logic                 vp_q, vp_d;

    logic [XW:0]          x_sum;
    logic [YW:0]          y_sum;
    logic                 empty;
    logic                 x_last, y_last;
    logic                 pix_on;

    assign x_sum = {1'b0, cmd_x} + {1'b0, cmd_w};
    assign y_sum = {1'b0, cmd_y} + {1'b0, cmd_h};

    assign empty = (cmd_w == '0) || (cmd_h == '0)
                || ({1'b0, cmd_x} >= XLIM)
                || ({1'b0, cmd_y} >= YLIM);

    assign x_last = ({1'b0, cx_q} == xend_q - X1);
    assign y_last = ({1'b0, cy_q} == yend_q - Y1);

`ifdef RECT_OUTLINE_EN
    logic outl_q, outl_d;

    // Scan timing is identical in outline mode; only the strobe is masked.
    assign pix_on = !outl_q || x_last || y_last
                 || (cx_q == x0_q) || (cy_q == y0_q);
`else
    assign pix_on = 1'b1;
`endif

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;
    assign vga_plot   = vp_q;

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        xend_d  = xend_q;
        yend_d  = yend_q;
        col_d   = col_q;
        last_d  = last_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        vc_d    = vc_q;
        vp_d    = 1'b0;
`ifdef RECT_OUTLINE_EN
        outl_d  = outl_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    x0_d   = cmd_x;
                    y0_d   = cmd_y;
                    cx_d   = cmd_x;
                    cy_d   = cmd_y;
                    col_d  = cmd_colour;
                    last_d = 1'b0;
                    xend_d = (x_sum > XLIM) ? XLIM : x_sum;
                    yend_d = (y_sum > YLIM) ? YLIM : y_sum;
`ifdef RECT_OUTLINE_EN
                    outl_d = cmd_outline;
`endif
                    state_d = empty ? DONE : FILL;
                end
            end
            FILL: begin
                // One extra cycle after the last pixel keeps
                // done from overlapping the final vga_plot.
                if (last_q) begin
                    state_d = DONE;
                end else if (!vga_stall) begin
                    vx_d = cx_q;
                    vy_d = cy_q;
                    vc_d = col_q;
                    vp_d = pix_on;
                    if (x_last) begin
                        cx_d = x0_q;
                        if (y_last) begin
                            last_d = 1'b1;
                        end else begin
                            cy_d = cy_q + YW'(1);
                        end
                    end else begin
                        cx_d = cx_q + XW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            xend_q  <= '0;
            yend_q  <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
            vp_q    <= 1'b0;
`ifdef RECT_OUTLINE_EN
            outl_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            xend_q  <= xend_d;
            yend_q  <= yend_d;
            col_q   <= col_d;
            last_q  <= last_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
            vp_q    <= vp_d;
`ifdef RECT_OUTLINE_EN
            outl_q  <= outl_d;
`endif
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine.
// Build with RECT_OUTLINE_EN to include the outline case.
module tb_rect_fill_engine;
    import vga_pkg::*;

    logic               CLOCK_50 = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [XW-1:0]      cmd_x;
    logic [YW-1:0]      cmd_y;
    logic [XW-1:0]      cmd_w;
    logic [YW-1:0]      cmd_h;
    logic [COLOR_W-1:0] cmd_colour;
    logic               cmd_outline;
    logic               vga_stall;
    logic [XW-1:0]      vga_x;
    logic [YW-1:0]      vga_y;
    logic [COLOR_W-1:0] vga_colour;
    logic               vga_plot;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    int exp_x[$];
    int exp_y[$];

    rect_fill_engine dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
`ifdef RECT_OUTLINE_EN
        .cmd_outline(cmd_outline),
`endif
        .vga_stall  (vga_stall),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Accept a command, then keep cmd_valid high with scrambled
    // fields so a busy engine must ignore them.
    task automatic send(input int x, input int y, input int w,
                        input int h, input int c, input bit ol);
        int n = 0;
        @(negedge CLOCK_50);
        while (!cmd_ready && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("ready_wait", int'(cmd_ready), 1);
        cmd_x       = XW'(x);
        cmd_y       = YW'(y);
        cmd_w       = XW'(w);
        cmd_h       = YW'(h);
        cmd_colour  = COLOR_W'(c);
        cmd_outline = ol;
        cmd_valid   = 1'b1;
        @(posedge CLOCK_50);
        #1;
        cmd_x      = ~cmd_x;
        cmd_y      = ~cmd_y;
        cmd_w      = 8'd1;
        cmd_h      = 7'd1;
        cmd_colour = ~cmd_colour;
    endtask

    // Sample at negedge k after the accept edge; stall is driven
    // high for edges following samples sf..st-1.
    task automatic collect(input string nm, input int c,
                           input int exp_dk, input int sf,
                           input int st);
        int idx = 0;
        int dk = -1;
        int both = 0;
        int hold_x = -1;
        for (int k = 0; k < 100 && dk < 0; k++) begin
            @(negedge CLOCK_50);
            if (k == 0) chk({nm, "_busy0"}, int'(busy), 1);
            if (done && cmd_ready) both++;
            if (vga_plot) begin
                if (idx < exp_x.size()) begin
                    chk({nm, "_x"}, int'(vga_x), exp_x[idx]);
                    chk({nm, "_y"}, int'(vga_y), exp_y[idx]);
                    chk({nm, "_c"}, int'(vga_colour), c);
                end
                idx++;
                hold_x = int'(vga_x);
            end else if (k >= sf + 1 && k <= st) begin
                chk({nm, "_hold"}, int'(vga_x), hold_x);
            end
            if (done) begin
                dk = k;
                chk({nm, "_busydone"}, int'(busy), 1);
                cmd_valid = 1'b0;
            end
            vga_stall = (k >= sf && k < st);
        end
        vga_stall = 1'b0;
        cmd_valid = 1'b0;
        chk({nm, "_npix"}, idx, exp_x.size());
        chk({nm, "_donek"}, dk, exp_dk);
        chk({nm, "_overlap"}, both, 0);
        @(negedge CLOCK_50);
        chk({nm, "_readyback"}, int'(cmd_ready), 1);
        chk({nm, "_plotidle"}, int'(vga_plot), 0);
        exp_x.delete();
        exp_y.delete();
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_x       = '0;
        cmd_y       = '0;
        cmd_w       = '0;
        cmd_h       = '0;
        cmd_colour  = '0;
        cmd_outline = 1'b0;
        vga_stall   = 1'b0;
        #22;
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_x", int'(vga_x), 0);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // 1: single pixel
        exp_x = '{4};
        exp_y = '{4};
        send(4, 4, 1, 1, 4, 1'b0);
        collect("pix", 4, 2, 99, 0);

        // 2: 3x2 raster
        exp_x = '{10, 11, 12, 10, 11, 12};
        exp_y = '{20, 20, 20, 21, 21, 21};
        send(10, 20, 3, 2, 2, 1'b0);
        collect("r3x2", 2, 7, 99, 0);

        // 3: clipping at bottom-right corner, then off-screen x
        exp_x = '{158, 159};
        exp_y = '{119, 119};
        send(158, 119, 4, 3, 7, 1'b0);
        collect("clip", 7, 3, 99, 0);
        send(200, 5, 3, 3, 1, 1'b0);
        collect("offx", 1, 0, 99, 0);

        // 4: zero width
        send(5, 5, 0, 4, 3, 1'b0);
        collect("w0", 3, 0, 99, 0);

        // 5: 4x1 with two stalled edges after the first pixel
        exp_x = '{30, 31, 32, 33};
        exp_y = '{40, 40, 40, 40};
        send(30, 40, 4, 1, 5, 1'b0);
        collect("stall", 5, 7, 1, 3);

        // 6: async reset in the middle of an 8x8 fill
        send(0, 0, 8, 8, 6, 1'b0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge CLOCK_50);
        chk("mid_plot", int'(vga_plot), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_plot", int'(vga_plot), 0);
        chk("arst_x", int'(vga_x), 0);
        chk("arst_y", int'(vga_y), 0);
        chk("arst_c", int'(vga_colour), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(cmd_ready), 1);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("post_plot", int'(vga_plot), 0);
        exp_x = '{7};
        exp_y = '{9};
        send(7, 9, 1, 1, 1, 1'b0);
        collect("after", 1, 2, 99, 0);

`ifdef RECT_OUTLINE_EN
        // 7: 3x3 outline, centre pixel masked, scan length unchanged
        exp_x = '{0, 1, 2, 0, 2, 0, 1, 2};
        exp_y = '{0, 0, 0, 1, 1, 2, 2, 2};
        send(0, 0, 3, 3, 6, 1'b1);
        collect("outl", 6, 10, 99, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
